// File: rtl/stream_cons2_pkg.sv
// Shared definitions for the stream_cons2 writer and future stream writers.
package stream_cons2_pkg;

   localparam int DEFAULT_N = 8;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EMIT0 = 2'd1,
      EMIT1 = 2'd2,
      PASS  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SEL_D1   = 2'd0,
      SEL_D2   = 2'd1,
      SEL_TAIL = 2'd2
   } out_sel_e;

   function automatic logic stream_xfer(input logic valid, input logic ready);
      return valid & ready;
   endfunction

endpackage

// File: rtl/stream_cons2_out_reg.sv
// Registered output stage of a stream writer: a data/valid register that is
// reloaded from one of three sources whenever the controller asks for it.
module stream_cons2_out_reg
   import stream_cons2_pkg::*;
#(
   parameter int N = DEFAULT_N
)
(
   input  logic         clk,
   input  logic         nrst,
   input  logic         load,
   input  out_sel_e     sel,
   input  logic [N-1:0] head0,
   input  logic [N-1:0] head1,
   input  logic [N-1:0] tail,
   input  logic         tail_valid,
   output logic [N-1:0] data,
   output logic         valid
);

   logic [N-1:0] next_data;
   logic         next_valid;

   // Heads are always valid; the tail carries its own valid bit.
   always_comb begin
      next_data  = head0;
      next_valid = TRUE;
      case (sel)
         SEL_D1: begin
            next_data  = head0;
            next_valid = TRUE;
         end
         SEL_D2: begin
            next_data  = head1;
            next_valid = TRUE;
         end
         SEL_TAIL: begin
            next_data  = tail;
            next_valid = tail_valid;
         end
         default: begin
            next_data  = head0;
            next_valid = FALSE;
         end
      endcase
   end

   // Without a load the register holds, which keeps data stable under backpressure.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         data  <= '0;
         valid <= FALSE;
      end else if (load) begin
         data  <= next_data;
         valid <= next_valid;
      end
   end

endmodule

// File: rtl/stream_cons2.sv
// Stream writer that emits d1, then d2, then forwards the tail stream.
module stream_cons2
   import stream_cons2_pkg::*;
#(
   parameter int N = DEFAULT_N
)
(
   input  logic         clk,
   input  logic         nrst,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic [N-1:0] in0,
   input  logic         in0_valid,
   output logic         in0_ready,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   output logic [N-1:0] out0,
   output logic         out0_valid,
   input  logic         out0_ready
);

   state_e       state;
   logic [N-1:0] d2_q;
   logic         out_valid_q;
   logic         in_ready_c;
   logic         in0_ready_c;
   logic         room;
   logic         load;
   out_sel_e     sel;
   logic         sync_xfer;
   logic         out0_xfer;

   assign out0_xfer = stream_xfer(out0_valid, out0_ready);
   assign sync_xfer = in_valid & in_ready_c;

   // Handshake readies and output-register load control, per state.
   // A new cons in PASS wins over the tail, so the tail element waits.
   always_comb begin
      in_ready_c  = FALSE;
      in0_ready_c = FALSE;
      room        = ~out0_valid | out0_ready;
      load        = FALSE;
      sel         = SEL_D1;
      case (state)
         IDLE: begin
            in_ready_c = TRUE;
            if (in_valid) begin
               load = TRUE;
               sel  = SEL_D1;
            end
         end
         EMIT0: begin
            if (out0_xfer) begin
               load = TRUE;
               sel  = SEL_D2;
            end
         end
         EMIT1: begin
            in0_ready_c = out0_ready;
            if (out0_xfer) begin
               load = TRUE;
               sel  = SEL_TAIL;
            end
         end
         PASS: begin
            in_ready_c = (~out_valid_q | out_ready) & room;
            if (in_valid & in_ready_c) begin
               load = TRUE;
               sel  = SEL_D1;
            end else begin
               in0_ready_c = room;
               if (room) begin
                  load = TRUE;
                  sel  = SEL_TAIL;
               end
            end
         end
         default: begin
            in_ready_c = FALSE;
         end
      endcase
   end

   // Sequencing through the two heads and the out_valid pulse of each cons.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         d2_q        <= '0;
         out_valid_q <= FALSE;
      end else begin
         case (state)
            IDLE: begin
               if (sync_xfer) begin
                  d2_q  <= in2;
                  state <= EMIT0;
               end
            end
            EMIT0: begin
               if (out0_xfer) begin
                  state <= EMIT1;
               end
            end
            EMIT1: begin
               if (out0_xfer) begin
                  out_valid_q <= TRUE;
                  state       <= PASS;
               end
            end
            PASS: begin
               if (sync_xfer) begin
                  d2_q        <= in2;
                  out_valid_q <= FALSE;
                  state       <= EMIT0;
               end else if (out_ready) begin
                  out_valid_q <= FALSE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   stream_cons2_out_reg #(.N(N)) u_out_reg (
      .clk        (clk),
      .nrst       (nrst),
      .load       (load),
      .sel        (sel),
      .head0      (in1),
      .head1      (d2_q),
      .tail       (in0),
      .tail_valid (in0_valid),
      .data       (out0),
      .valid      (out0_valid)
   );

   assign in_ready  = in_ready_c;
   assign in0_ready = in0_ready_c;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_cons2.sv
// Self-checking bench for stream_cons2: a queue model of the output stream
// plus directed scenarios with hand-computed output sequences.
module tb_stream_cons2;

   localparam int N = 8;

   logic         clk        = 1'b0;
   logic         nrst       = 1'b1;
   logic         in_valid   = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready  = 1'b1;
   logic [N-1:0] in0        = '0;
   logic         in0_valid  = 1'b0;
   logic         in0_ready;
   logic [N-1:0] in1        = '0;
   logic [N-1:0] in2        = '0;
   logic [N-1:0] out0;
   logic         out0_valid;
   logic         out0_ready = 1'b1;

   int checks = 0;
   int errors = 0;
   int tailVal = 1;

   logic [N-1:0] expQ[$];
   logic [N-1:0] outLog[$];
   logic [N-1:0] expSeq[$];
   int           heads = 0;
   logic         ovExp = 1'b0;
   logic         started = 1'b0;
   logic         hadHold = 1'b0;
   logic [N-1:0] heldVal = '0;
   int           ovCycles = 0;
   logic [N-1:0] ovAtValue = '0;
   logic         qValid, expInReady, expIn0Ready, syncNow, ovNext;

   stream_cons2 #(.N(N)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .in0        (in0),
      .in0_valid  (in0_valid),
      .in0_ready  (in0_ready),
      .in1        (in1),
      .in2        (in2),
      .out0       (out0),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkLog(input string name);
      checkOutput({name, "_len"}, outLog.size(), expSeq.size());
      for (int i = 0; i < expSeq.size() && i < outLog.size(); i++)
         checkOutput(name, outLog[i], expSeq[i]);
   endtask

   // One cycle of stimulus; the tail source advances when its element was taken.
   task automatic applyStimulus(input logic iv, input logic [N-1:0] d1, input logic [N-1:0] d2,
                                input logic tv, input logic o0r, input logic ordy);
      logic took;
      in_valid   = iv;
      in1        = d1;
      in2        = d2;
      in0_valid  = tv;
      out0_ready = o0r;
      out_ready  = ordy;
      in0        = tailVal[N-1:0];
      @(negedge clk);
      took = in0_valid && in0_ready;
      @(posedge clk);
      #1;
      if (took) tailVal++;
      in0      = tailVal[N-1:0];
      in_valid = 1'b0;
   endtask

   task automatic doReset();
      nrst      = 1'b0;
      in_valid  = 1'b0;
      in0_valid = 1'b0;
      out0_ready = 1'b1;
      out_ready = 1'b1;
      tailVal   = 1;
      in0       = 8'd1;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   // Reference model: the output stream is the queue of accepted elements
   // (two heads per cons, then consumed tail elements), checked every cycle.
   always @(negedge clk) begin
      if (!nrst) begin
         checkOutput("rst_out0_valid", out0_valid, 0);
         checkOutput("rst_out_valid", out_valid, 0);
         checkOutput("rst_in0_ready", in0_ready, 0);
         checkOutput("rst_in_ready", in_ready, 1);
         checkOutput("rst_out0", out0, 0);
         expQ.delete();
         outLog.delete();
         heads    = 0;
         ovExp    = 1'b0;
         started  = 1'b0;
         hadHold  = 1'b0;
         ovCycles = 0;
      end else begin
         qValid = (expQ.size() != 0);
         if (hadHold) begin
            checkOutput("hold_valid", out0_valid, 1);
            checkOutput("hold_data", out0, heldVal);
         end
         checkOutput("out0_valid", out0_valid, qValid);
         checkOutput("out_valid", out_valid, ovExp);
         expInReady = (heads == 0) && (!ovExp || out_ready) && (!qValid || out0_ready);
         checkOutput("in_ready", in_ready, expInReady);
         syncNow = in_valid && expInReady;
         if (heads == 2)      expIn0Ready = 1'b0;
         else if (heads == 1) expIn0Ready = out0_ready;
         else if (!started)   expIn0Ready = 1'b0;
         else                 expIn0Ready = !syncNow && (!qValid || out0_ready);
         checkOutput("in0_ready", in0_ready, expIn0Ready);
         if (out_valid) begin
            ovCycles++;
            ovAtValue = out0;
         end
         ovNext = ovExp && !out_ready;
         if (out0_valid && out0_ready) begin
            outLog.push_back(out0);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL out0_extra: got %0d expected no element at %0t", out0, $time);
            end else begin
               checkOutput("out0_data", out0, expQ.pop_front());
            end
            if (heads > 0) begin
               heads--;
               if (heads == 0) ovNext = 1'b1;
            end
         end
         if (syncNow) begin
            expQ.push_back(in1);
            expQ.push_back(in2);
            heads   = 2;
            ovNext  = 1'b0;
            started = 1'b1;
         end else if (in0_valid && expIn0Ready) begin
            expQ.push_back(in0);
         end
         ovExp   = ovNext;
         hadHold = out0_valid && !out0_ready;
         heldVal = out0;
      end
   end

   initial begin
      #1;
      doReset();

      // Straight-through: 5, 9, then tail 1, 2, 3.
      applyStimulus(1, 5, 9, 1, 1, 1);
      repeat (5) applyStimulus(0, 0, 0, 1, 1, 1);
      expSeq = '{5, 9, 1, 2, 3};
      checkLog("seq_basic");
      checkOutput("ov_cycles_basic", ovCycles, 1);
      checkOutput("ov_at_third", ovAtValue, 1);

      // Downstream ready toggling.
      doReset();
      applyStimulus(1, 5, 9, 1, 1, 1);
      for (int k = 1; k <= 8; k++) applyStimulus(0, 0, 0, 1, (k % 2 == 1), 1);
      expSeq = '{5, 9, 1, 2};
      checkLog("seq_toggle");

      // out_ready held low after d2.
      doReset();
      applyStimulus(1, 5, 9, 1, 1, 0);
      for (int k = 1; k <= 8; k++) applyStimulus(0, 0, 0, 1, 1, (k >= 7));
      expSeq = '{5, 9, 1, 2, 3, 4, 5, 6};
      checkLog("seq_outhold");
      checkOutput("ov_cycles_hold", ovCycles, 5);

      // New cons while the tail is flowing.
      doReset();
      applyStimulus(1, 5, 9, 1, 1, 1);
      repeat (3) applyStimulus(0, 0, 0, 1, 1, 1);
      applyStimulus(1, 7, 8, 1, 1, 1);
      repeat (4) applyStimulus(0, 0, 0, 1, 1, 1);
      expSeq = '{5, 9, 1, 2, 7, 8, 3, 4};
      checkLog("seq_recons");
      checkOutput("ov_cycles_recons", ovCycles, 2);

      // Asynchronous reset while d2 is pending.
      doReset();
      applyStimulus(1, 5, 9, 1, 1, 1);
      applyStimulus(0, 0, 0, 1, 1, 1);
      out0_ready = 1'b0;
      nrst = 1'b0;
      #1;
      checkOutput("async_out0_valid", out0_valid, 0);
      checkOutput("async_out_valid", out_valid, 0);
      checkOutput("async_in0_ready", in0_ready, 0);
      checkOutput("async_in_ready", in_ready, 1);
      doReset();
      applyStimulus(1, 3, 4, 1, 1, 1);
      repeat (3) applyStimulus(0, 0, 0, 1, 1, 1);
      expSeq = '{3, 4, 1};
      checkLog("seq_after_reset");

      // Empty tail.
      doReset();
      applyStimulus(1, 5, 9, 0, 1, 0);
      for (int k = 1; k <= 5; k++) applyStimulus(0, 0, 0, 0, 1, (k >= 4));
      expSeq = '{5, 9};
      checkLog("seq_empty_tail");
      checkOutput("empty_out0_valid", out0_valid, 0);
      checkOutput("ov_cycles_empty", ovCycles, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_cons2.md
Name: stream_cons2

Overview:
- Stream producer/writer primitive: the converse of the stream-consuming `ap` primitives, which pop ints off a stream.
- Takes two ints plus a tail stream under the `sync` handshake. Emits a registered output stream: first int, then second int, then every tail element forwarded.
- Used wherever compiled code builds a stream with two pushes (`d1 : d2 : tail`). Its output feeds `ap` readers directly.

Parameters:
- N, 8, int/stream element width (`intN`).

Ports:
- clk  in  1  single clock, all state on posedge.
- nrst  in  1  asynchronous, active-low reset.
- in_valid  in  1  sync handshake: inputs valid.
- in_ready  out  1  sync handshake: block accepts inputs.
- out_valid  out  1  sync handshake: both head elements have been emitted.
- out_ready  in  1  sync handshake: downstream acknowledges out_valid.
- in0  in  N  tail stream data (sIn).
- in0_valid  in  1  tail element valid.
- in0_ready  out  1  tail element consumed.
- in1  in  N  first element pushed (d1).
- in2  in  N  second element pushed (d2).
- out0  out  N  output stream data, registered.
- out0_valid  out  1  output element valid.
- out0_ready  in  1  downstream stream consumer ready.

Behaviour:
- Reset (nrst low, async): state=IDLE; out0=0, out0_valid=0, out_valid=0, in0_ready=0, in_ready=1, latched d2=0. Reset mid-emission drops any pending element; nothing is replayed.
- Stream transfer: out0_valid & out0_ready at a posedge. out0 and out0_valid stay stable while out0_valid=1 and out0_ready=0.
- Sync transfer: in_valid & in_ready at a posedge.
- States: IDLE, EMIT0, EMIT1, PASS.
- IDLE:
  - in_ready=1, in0_ready=0.
  - On sync transfer: out0<=in1, out0_valid<=1, d2<=in2, go to EMIT0.
- EMIT0:
  - in_ready=0, in0_ready=0.
  - On stream transfer: out0<=d2, stays valid, go to EMIT1.
- EMIT1:
  - in_ready=0, in0_ready=out0_ready.
  - On stream transfer: out0<=in0, out0_valid<=in0_valid, out_valid<=1, go to PASS.
- PASS (1-deep pipeline register):
  - in0_ready = !out0_valid | out0_ready.
  - When in0_ready: out0<=in0, out0_valid<=in0_valid.
  - out_valid holds until sampled with out_ready=1, then clears to 0. It pulses at most once per cons.
- Leaving PASS (new cons):
  - in_ready = (out_valid==0 or out_ready) & (!out0_valid | out0_ready).
  - On sync transfer: in0_ready is forced to 0 that cycle and the tail is not consumed. out0<=in1, out0_valid<=1, d2<=in2, go to EMIT0, out_valid<=0 (or cleared by the same-cycle handshake).
- Latency (out0_ready=1 throughout, sync transfer at edge t): d1 valid t..t+1, d2 t+1..t+2, first tail element at t+2..t+3 if in0_valid. out_valid rises at edge t+2.
- Backpressure: out0_ready=0 freezes state and out0 in every state. No element is lost or duplicated.
- Empty tail: in0_valid=0 in PASS gives out0_valid=0 after drain. No bubble insertion is otherwise allowed.
- Simultaneous events:
  - out_ready and a new in_valid in the same PASS cycle: both handshakes complete.
  - Tail element arrival with a new cons: the tail element is not consumed.
- Widths: all data N bits, no arithmetic, no truncation.

Decomposition:
- Shared package/include (primitives.v): `intN`, `true`/`false`, the state encoding localparams, and the `stream`/`int` wire/reg macros.
- One natural sub-module: stream_out_reg, the output valid/ready register with load-enable and mux select. Reused by future stream writers (cons1, consN).

Test Plan:
- Push in1=5, in2=9, in0 counting 1,2,3 (valid always), out0_ready=1, out_ready=1 -> out0 = 5,9,1,2,3 on consecutive cycles; out_valid high exactly one cycle, at the third output cycle.
- Same stimulus with out0_ready toggling 1,0,1,0 -> out0 sequence 5,9,1,2 with each value held through ready=0 cycles; no drops or repeats.
- out_ready=0 held for 4 cycles after d2 -> out_valid stays 1 for those 4 cycles; tail keeps flowing 1,2,3,4; in_ready=0 throughout.
- In PASS, in_valid=1 with in1=7, in2=8 while in0_valid=1 -> tail stops (in0_ready=0), out0 = 7 then 8; tail resumes afterwards at the element that was not consumed.
- Assert nrst=0 during EMIT1 (out0=9 pending) -> out0_valid, out_valid and in0_ready go to 0 immediately (async), in_ready=1; after release, a new push of 3,4 emits 3,4 normally.
- in0_valid=0 after both heads -> out0_valid drops to 0 after d2; out_valid still asserted and handshakes normally.
